// File: rtl/cv32e41p_tb_obi_mem_pkg.sv
// -----------------------------------------------------------------------------
// cv32e41p_tb_obi_mem_pkg
// Shared constants and types for the multi-port OBI testbench memory model:
//   - magic values and offsets of the pass/fail/exit control region
//   - the 8-bit Galois LFSR feedback mask and its step function
//   - the per-port grant FSM state type
// -----------------------------------------------------------------------------
package cv32e41p_tb_obi_mem_pkg;

  localparam logic [31:0] PASS_MAGIC    = 32'd123456789;
  localparam logic [31:0] FAIL_MAGIC    = 32'd1;
  localparam logic [3:0]  CTRL_PASS_OFS = 4'h0;
  localparam logic [3:0]  CTRL_EXIT_OFS = 4'h4;

  // x^8 + x^6 + x^5 + x^4 + 1 in right-shifting Galois form
  localparam logic [7:0]  LFSR_POLY     = 8'hB8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    STALL = 1'b1
  } grant_state_e;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/cv32e41p_tb_obi_port.sv
// -----------------------------------------------------------------------------
// cv32e41p_tb_obi_port
// One OBI slave port of the testbench memory: grant FSM with LFSR-driven
// random stall insertion, and a fixed-latency response shift pipeline.
//
// Ports:
//   i_clk       clock
//   i_rst_n     asynchronous active-low reset
//   i_stall_en  enables random grant stalls
//   i_req       OBI request of this port
//   i_rdata     response data to carry for a transfer in this cycle
//               (already sampled RAM data, or zero)
//   o_gnt       grant (combinational, forced low while in reset)
//   o_rvalid    response valid, RESP_LATENCY cycles after the transfer
//   o_rdata     response data accompanying o_rvalid
// -----------------------------------------------------------------------------
module cv32e41p_tb_obi_port
  import cv32e41p_tb_obi_mem_pkg::*;
#(
  parameter int unsigned RESP_LATENCY  = 1,
  parameter int unsigned MAX_GNT_STALL = 3,
  parameter logic [7:0]  SEED          = 8'hA4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall_en,
  input  logic        i_req,
  input  logic [31:0] i_rdata,
  output logic        o_gnt,
  output logic        o_rvalid,
  output logic [31:0] o_rdata
);

  localparam int unsigned CNT_W = $clog2(MAX_GNT_STALL + 2);

  grant_state_e     r_state;
  grant_state_e     w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_draw;
  logic [7:0]       r_lfsr;
  logic             w_gnt;
  logic             w_xfer;

  // Stall length drawn from the current LFSR value when a request arrives.
  assign w_draw = CNT_W'(32'(r_lfsr) % (MAX_GNT_STALL + 1));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_gnt       = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_req) begin
          if (!i_stall_en || (w_draw == '0)) begin
            w_gnt = 1'b1;
          end else begin
            w_state_nxt = STALL;
            w_cnt_nxt   = w_draw;
          end
        end
      end
      STALL: begin
        // The IDLE cycle already counted as the first stall cycle, so the
        // grant falls on the cycle where the counter steps from 1 to 0.
        if (i_req) begin
          if (r_cnt <= CNT_W'(1)) begin
            w_gnt       = 1'b1;
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Gate with reset so the grant drops as soon as reset is asserted.
  assign o_gnt  = w_gnt & i_rst_n;
  assign w_xfer = i_req & o_gnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_lfsr  <= SEED;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_xfer) begin
        r_lfsr <= lfsr_step(r_lfsr);
      end
    end
  end

  logic [RESP_LATENCY-1:0] r_vld;
  logic [31:0]             r_data [RESP_LATENCY];

  // Response pipeline: one stage per latency cycle, no backpressure.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld <= '0;
      for (int i = 0; i < int'(RESP_LATENCY); i++) begin
        r_data[i] <= '0;
      end
    end else begin
      r_vld[0]  <= w_xfer;
      r_data[0] <= w_xfer ? i_rdata : 32'h0;
      for (int i = 1; i < int'(RESP_LATENCY); i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_data[i] <= r_data[i-1];
      end
    end
  end

  assign o_rvalid = r_vld[RESP_LATENCY-1];
  assign o_rdata  = r_data[RESP_LATENCY-1];

endmodule

// File: rtl/cv32e41p_tb_obi_mem.sv
// -----------------------------------------------------------------------------
// cv32e41p_tb_obi_mem
// Multi-port OBI slave memory model for the cv32e41p testbench. NUM_PORTS
// independent ports share one byte-addressed RAM; each port has random grant
// stalls and a fixed response latency. A 16-byte control region reports
// pass/fail and an exit code.
//
// Ports:
//   clk_i           clock
//   rst_ni          asynchronous active-low reset
//   stall_en_i      enables random grant stalls on all ports
//   req_i[p]        OBI request
//   addr_i[p]       byte address (word aligned)
//   we_i[p]         write enable
//   be_i[p]         byte enables
//   wdata_i[p]      write data
//   gnt_o[p]        grant
//   rvalid_o[p]     response valid
//   rdata_o[p]      read data; zero for writes and control-region accesses
//   tests_passed_o  sticky pass flag
//   tests_failed_o  sticky fail flag
//   exit_valid_o    one-cycle exit pulse
//   exit_value_o    exit code, held until the next exit write or reset
// -----------------------------------------------------------------------------
module cv32e41p_tb_obi_mem
  import cv32e41p_tb_obi_mem_pkg::*;
#(
  parameter int unsigned NUM_PORTS      = 2,
  parameter int unsigned RAM_ADDR_WIDTH = 20,
  parameter int unsigned RESP_LATENCY   = 1,
  parameter int unsigned MAX_GNT_STALL  = 3,
  parameter logic [7:0]  LFSR_SEED      = 8'hA5,
  parameter logic [31:0] CTRL_BASE      = 32'h2000_0000
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       stall_en_i,
  input  logic [NUM_PORTS-1:0]       req_i,
  input  logic [NUM_PORTS-1:0][31:0] addr_i,
  input  logic [NUM_PORTS-1:0]       we_i,
  input  logic [NUM_PORTS-1:0][3:0]  be_i,
  input  logic [NUM_PORTS-1:0][31:0] wdata_i,
  output logic [NUM_PORTS-1:0]       gnt_o,
  output logic [NUM_PORTS-1:0]       rvalid_o,
  output logic [NUM_PORTS-1:0][31:0] rdata_o,
  output logic                       tests_passed_o,
  output logic                       tests_failed_o,
  output logic                       exit_valid_o,
  output logic [31:0]                exit_value_o
);

  localparam int unsigned IDX_W = RAM_ADDR_WIDTH - 2;
  localparam int unsigned WORDS = 2 ** IDX_W;

  logic [31:0]                r_mem [WORDS];
  logic [NUM_PORTS-1:0]       w_xfer;
  logic [NUM_PORTS-1:0]       w_ctrl;
  logic [NUM_PORTS-1:0][IDX_W-1:0] w_idx;
  logic [NUM_PORTS-1:0][31:0] w_rd;

  logic        r_passed;
  logic        r_failed;
  logic        r_exit_valid;
  logic [31:0] r_exit_value;

  for (genvar p = 0; p < int'(NUM_PORTS); p++) begin : gen_port
    assign w_idx[p]  = addr_i[p][RAM_ADDR_WIDTH-1:2];
    assign w_ctrl[p] = (addr_i[p][31:4] == CTRL_BASE[31:4]);
    assign w_xfer[p] = req_i[p] & gnt_o[p];
    // Reads sample RAM in the transfer cycle, ahead of any same-cycle write.
    assign w_rd[p]   = (!we_i[p] && !w_ctrl[p]) ? r_mem[w_idx[p]] : 32'h0;

    cv32e41p_tb_obi_port #(
      .RESP_LATENCY  (RESP_LATENCY),
      .MAX_GNT_STALL (MAX_GNT_STALL),
      .SEED          (LFSR_SEED ^ 8'(p + 1))
    ) u_port (
      .i_clk      (clk_i),
      .i_rst_n    (rst_ni),
      .i_stall_en (stall_en_i),
      .i_req      (req_i[p]),
      .i_rdata    (w_rd[p]),
      .o_gnt      (gnt_o[p]),
      .o_rvalid   (rvalid_o[p]),
      .o_rdata    (rdata_o[p])
    );
  end

  // RAM writes are not reset. Ports are visited from highest to lowest index
  // so the lowest-index port's byte lands last and wins a same-cycle clash.
  always_ff @(posedge clk_i) begin
    for (int p = int'(NUM_PORTS) - 1; p >= 0; p--) begin
      if (w_xfer[p] && we_i[p] && !w_ctrl[p]) begin
        for (int b = 0; b < 4; b++) begin
          if (be_i[p][b]) begin
            r_mem[w_idx[p]][b*8 +: 8] <= wdata_i[p][b*8 +: 8];
          end
        end
      end
    end
  end

  // Control region decode; same descending order gives port 0 exit priority.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_passed     <= 1'b0;
      r_failed     <= 1'b0;
      r_exit_valid <= 1'b0;
      r_exit_value <= '0;
    end else begin
      r_exit_valid <= 1'b0;
      for (int p = int'(NUM_PORTS) - 1; p >= 0; p--) begin
        if (w_xfer[p] && we_i[p] && w_ctrl[p]) begin
          if (addr_i[p][3:0] == CTRL_PASS_OFS) begin
            if (wdata_i[p] == PASS_MAGIC) begin
              r_passed <= 1'b1;
            end
            if (wdata_i[p] == FAIL_MAGIC) begin
              r_failed <= 1'b1;
            end
          end
          if (addr_i[p][3:0] == CTRL_EXIT_OFS) begin
            r_exit_valid <= 1'b1;
            r_exit_value <= wdata_i[p];
          end
        end
      end
    end
  end

  assign tests_passed_o = r_passed;
  assign tests_failed_o = r_failed;
  assign exit_valid_o   = r_exit_valid;
  assign exit_value_o   = r_exit_value;

endmodule

// File: tb/tb_cv32e41p_tb_obi_mem.sv
// -----------------------------------------------------------------------------
// tb_cv32e41p_tb_obi_mem
// Two instances share the same stimulus: one with response latency 1, one
// with latency 3. A driver issues OBI transactions and pushes the expected
// response (data and due cycle) into a per-instance, per-port queue; a monitor
// pops and compares whenever an rvalid appears.
// -----------------------------------------------------------------------------
module tb_cv32e41p_tb_obi_mem;

  localparam int          MAXS = 3;
  localparam logic [31:0] CTRL = 32'h2000_0000;

  logic              clk;
  logic              rst_n;
  logic              stall_en;
  logic [1:0]        req;
  logic [1:0]        we;
  logic [1:0][31:0]  addr;
  logic [1:0][3:0]   be;
  logic [1:0][31:0]  wdata;

  logic [1:0]        gnt1, gnt3, rv1, rv3;
  logic [1:0][31:0]  rd1, rd3;
  logic              pass1, fail1, exv1, pass3, fail3, exv3;
  logic [31:0]       exval1, exval3;

  cv32e41p_tb_obi_mem #(.RESP_LATENCY(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .stall_en_i(stall_en),
    .req_i(req), .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata),
    .gnt_o(gnt1), .rvalid_o(rv1), .rdata_o(rd1),
    .tests_passed_o(pass1), .tests_failed_o(fail1),
    .exit_valid_o(exv1), .exit_value_o(exval1)
  );

  cv32e41p_tb_obi_mem #(.RESP_LATENCY(3)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .stall_en_i(stall_en),
    .req_i(req), .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata),
    .gnt_o(gnt3), .rvalid_o(rv3), .rdata_o(rd3),
    .tests_passed_o(pass3), .tests_failed_o(fail3),
    .exit_valid_o(exv3), .exit_value_o(exval3)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] due;
  } sb_t;

  sb_t         sbq [4][$];          // index: inst*2 + port (inst 0 = lat 1)
  logic [31:0] mm [bit [17:0]];     // reference memory, word indexed
  logic [7:0]  mlfsr [2];
  int          total, bad, cyc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] lfsr_adv(input logic [7:0] s);
    logic [7:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 8'hB8;
    return n;
  endfunction

  function automatic logic is_ctrl(input logic [31:0] a);
    return a[31:4] == CTRL[31:4];
  endfunction

  function automatic logic [31:0] exp_read(input logic w, input logic [31:0] a);
    if (w || is_ctrl(a)) return 32'h0;
    return mm.exists(a[19:2]) ? mm[a[19:2]] : 32'h0;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    logic [31:0] w;
    if (is_ctrl(a)) return;
    w = mm.exists(a[19:2]) ? mm[a[19:2]] : 32'h0;
    for (int i = 0; i < 4; i++) if (b[i]) w[i*8 +: 8] = d[i*8 +: 8];
    mm[a[19:2]] = w;
  endtask

  task automatic push(input int p, input logic [31:0] d);
    sb_t e;
    e.data = d;
    e.due  = 32'(cyc + 1);
    sbq[p].push_back(e);
    e.due  = 32'(cyc + 3);
    sbq[2 + p].push_back(e);
  endtask

  task automatic realign();
    @(posedge clk);
    #1;
  endtask

  // Single-port transaction; returns 1 time unit after the ending clock edge.
  task automatic issue(input int p, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d);
    int n, k;
    bit done;
    k = stall_en ? int'(mlfsr[p] % 8'(MAXS + 1)) : 0;
    req[p] = 1'b1; we[p] = w; addr[p] = a; be[p] = b; wdata[p] = d;
    n = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (gnt1[p] || gnt3[p]) begin
        chk($sformatf("gnt_lat1_p%0d", p), 32'(gnt1[p]), 32'd1);
        chk($sformatf("gnt_lat3_p%0d", p), 32'(gnt3[p]), 32'd1);
        chk($sformatf("stall_cycles_p%0d", p), 32'(n), 32'(k));
        push(p, exp_read(w, a));
        if (w) model_write(a, b, d);
        mlfsr[p] = lfsr_adv(mlfsr[p]);
        done = 1'b1;
      end else if (n >= 4 * (MAXS + 1)) begin
        total++;
        bad++;
        $display("FAIL gnt_timeout_p%0d: no grant after %0d cycles, expected after %0d", p, n, k);
        done = 1'b1;
      end else begin
        n++;
      end
      realign();
    end
    req[p] = 1'b0;
  endtask

  // Both ports in the same cycle, stalls disabled.
  task automatic issue2(input logic w0, input logic [31:0] a0, input logic [3:0] b0,
                        input logic [31:0] d0, input logic w1, input logic [31:0] a1,
                        input logic [3:0] b1, input logic [31:0] d1);
    req = 2'b11; we = {w1, w0}; addr[0] = a0; addr[1] = a1;
    be[0] = b0; be[1] = b1; wdata[0] = d0; wdata[1] = d1;
    @(negedge clk);
    chk("dual_gnt_lat1", 32'(gnt1), 32'd3);
    chk("dual_gnt_lat3", 32'(gnt3), 32'd3);
    push(0, exp_read(w0, a0));
    push(1, exp_read(w1, a1));
    // port 0 applied last: it owns every byte both ports write
    if (w1) model_write(a1, b1, d1);
    if (w0) model_write(a0, b0, d0);
    mlfsr[0] = lfsr_adv(mlfsr[0]);
    mlfsr[1] = lfsr_adv(mlfsr[1]);
    realign();
    req = 2'b00;
  endtask

  task automatic monitor();
    logic        v;
    logic [31:0] d;
    sb_t         e;
    forever begin
      @(negedge clk);
      for (int q = 0; q < 4; q++) begin
        v = (q < 2) ? rv1[q % 2] : rv3[q % 2];
        d = (q < 2) ? rd1[q % 2] : rd3[q % 2];
        if (v) begin
          if (sbq[q].size() == 0) begin
            chk($sformatf("spurious_rvalid_q%0d", q), 32'(v), 32'd0);
          end else begin
            e = sbq[q].pop_front();
            chk($sformatf("rdata_q%0d", q), d, e.data);
            chk($sformatf("rvalid_cycle_q%0d", q), 32'(cyc), e.due);
          end
        end
        while (sbq[q].size() > 0 && int'(sbq[q][0].due) < cyc) begin
          e = sbq[q].pop_front();
          total++;
          bad++;
          $display("FAIL rvalid_missing_q%0d: no rvalid by cycle %0d, due %0d", q, cyc, e.due);
        end
      end
    end
  endtask

  task automatic count_cycles();
    forever begin
      @(posedge clk);
      cyc++;
    end
  endtask

  initial begin
    rst_n = 1'b0; stall_en = 1'b0; req = '0; we = '0;
    addr = '0; be = '0; wdata = '0;
    total = 0; bad = 0; cyc = 0;
    mlfsr[0] = 8'hA5 ^ 8'h01;
    mlfsr[1] = 8'hA5 ^ 8'h02;
    fork
      monitor();
      count_cycles();
    join_none

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'({gnt3, gnt1}), 32'd0);
    chk("rst_rvalid", 32'({rv3, rv1}), 32'd0);
    chk("rst_flags", 32'({pass1, fail1, exv1, pass3, fail3, exv3}), 32'd0);
    chk("rst_exit_value1", exval1, 32'd0);
    chk("rst_exit_value3", exval3, 32'd0);
    rst_n = 1'b1;
    realign();

    // basic write/read, no stalls
    issue(0, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF);
    issue(0, 1'b0, 32'h100, 4'hF, 32'h0);

    // byte enables over a zero word
    issue(0, 1'b1, 32'h104, 4'hF, 32'h0);
    issue(0, 1'b1, 32'h104, 4'b0101, 32'h11223344);
    issue(0, 1'b0, 32'h104, 4'hF, 32'h0);

    // same-cycle conflicts
    issue2(1'b1, 32'h200, 4'hF, 32'hAAAAAAAA, 1'b1, 32'h200, 4'hF, 32'h55555555);
    issue(1, 1'b0, 32'h200, 4'hF, 32'h0);
    issue2(1'b1, 32'h200, 4'hF, 32'h12345678, 1'b0, 32'h200, 4'hF, 32'h0);
    issue(0, 1'b0, 32'h200, 4'hF, 32'h0);
    issue2(1'b1, 32'h204, 4'h3, 32'h00001111, 1'b1, 32'h204, 4'hF, 32'h22223333);
    issue(1, 1'b0, 32'h204, 4'hF, 32'h0);

    // random grant stalls, back-to-back reads on port 1
    stall_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      issue(1, 1'b0, (i % 2 == 0) ? 32'h100 + 32'(4 * (i % 4) / 2) : 32'h200 + 32'(4 * ((i / 2) % 2)),
            4'hF, 32'h0);
    end
    stall_en = 1'b0;

    // control region
    issue(0, 1'b1, 32'h0, 4'hF, 32'hCAFEF00D);
    issue(0, 1'b1, CTRL, 4'hF, 32'd5);
    @(negedge clk);
    chk("ignored_ctrl_flags", 32'({pass1, fail1, pass3, fail3}), 32'd0);
    realign();
    issue(1, 1'b1, CTRL, 4'hF, 32'd123456789);
    @(negedge clk);
    chk("passed_flags", 32'({pass1, fail1, pass3, fail3}), 32'b1010);
    realign();
    issue(0, 1'b1, CTRL + 32'h4, 4'hF, 32'd7);
    @(negedge clk);
    chk("exit_pulse", 32'({exv1, exv3}), 32'b11);
    chk("exit_value1", exval1, 32'd7);
    chk("exit_value3", exval3, 32'd7);
    @(negedge clk);
    chk("exit_pulse_end", 32'({exv1, exv3}), 32'b00);
    chk("exit_value_held", exval3, 32'd7);
    realign();
    issue(1, 1'b0, CTRL, 4'hF, 32'h0);
    issue(0, 1'b0, 32'h0, 4'hF, 32'h0);
    issue(1, 1'b1, CTRL, 4'hF, 32'd1);
    @(negedge clk);
    chk("failed_flags", 32'({pass1, fail1, pass3, fail3}), 32'b1111);
    realign();
    issue2(1'b1, CTRL + 32'h4, 4'hF, 32'h11, 1'b1, CTRL + 32'h4, 4'hF, 32'h22);
    @(negedge clk);
    chk("dual_exit_pulse", 32'({exv1, exv3}), 32'b11);
    chk("dual_exit_value", exval1, 32'h11);
    realign();

    // randomized traffic over a small pre-initialised pool
    for (int i = 0; i < 8; i++) issue(0, 1'b1, 32'h400 + 32'(4 * i), 4'hF, $urandom);
    for (int i = 0; i < 60; i++) begin
      stall_en = 1'($urandom_range(0, 1));
      issue(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            32'h400 + 32'(4 * $urandom_range(0, 7)), 4'($urandom_range(0, 15)), $urandom);
    end
    stall_en = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // reset with reads in flight
    issue(0, 1'b0, 32'h100, 4'hF, 32'h0);
    issue(0, 1'b0, 32'h104, 4'hF, 32'h0);
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h200;
    #1;
    chk("pre_rst_gnt", 32'(gnt1[0]), 32'd1);
    #1;
    rst_n = 1'b0;
    for (int q = 0; q < 4; q++) sbq[q].delete();
    mlfsr[0] = 8'hA5 ^ 8'h01;
    mlfsr[1] = 8'hA5 ^ 8'h02;
    #1;
    chk("mid_rst_gnt", 32'({gnt3, gnt1}), 32'd0);
    chk("mid_rst_rvalid", 32'({rv3, rv1}), 32'd0);
    chk("mid_rst_flags", 32'({pass1, fail1, exv1, pass3, fail3, exv3}), 32'd0);
    chk("mid_rst_exit_value", exval3, 32'd0);
    req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    issue(1, 1'b0, 32'h100, 4'hF, 32'h0);
    stall_en = 1'b1;
    issue(1, 1'b0, 32'h104, 4'hF, 32'h0);
    issue(0, 1'b0, 32'h204, 4'hF, 32'h0);
    stall_en = 1'b0;

    repeat (8) @(posedge clk);
    @(negedge clk);
    for (int q = 0; q < 4; q++) chk($sformatf("sb_drained_q%0d", q), 32'(sbq[q].size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cv32e41p_tb_obi_mem.md
Name: cv32e41p_tb_obi_mem

Overview:
- Multi-port OBI slave memory model for the cv32e41p testbench subsystem.
- Generalises the single instr/data RAM plus stdout/exit pseudo-peripheral to NUM_PORTS independent OBI ports sharing one byte-addressed RAM.
- Adds LFSR-driven grant stalls and a parametrised fixed response latency, so the core's fetch and LSU handshakes are stressed.
- Decodes a small control region for pass/fail/exit reporting.

Parameters:
- NUM_PORTS, 2, number of OBI slave ports (port 0 has the highest write priority).
- RAM_ADDR_WIDTH, 20, byte address bits decoded into RAM; RAM size is 2**RAM_ADDR_WIDTH bytes.
- RESP_LATENCY, 1, cycles from grant to rvalid; must be ≥1.
- MAX_GNT_STALL, 3, maximum stall cycles inserted before a grant.
- LFSR_SEED, 8'hA5, base seed; port p seed = LFSR_SEED ^ (p+1), must be nonzero.
- CTRL_BASE, 32'h2000_0000, base address of the control region.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- stall_en_i  in  1  enables random grant stalls
- req_i  in  NUM_PORTS  OBI request per port
- addr_i  in  NUM_PORTS x 32  byte address, word aligned
- we_i  in  NUM_PORTS  write enable
- be_i  in  NUM_PORTS x 4  byte enables
- wdata_i  in  NUM_PORTS x 32  write data
- gnt_o  out  NUM_PORTS  grant
- rvalid_o  out  NUM_PORTS  response valid
- rdata_o  out  NUM_PORTS x 32  read data; 0 for writes and control-region accesses
- tests_passed_o  out  1  sticky pass flag
- tests_failed_o  out  1  sticky fail flag
- exit_valid_o  out  1  one-cycle exit pulse
- exit_value_o  out  32  exit code, held

Behaviour:
- Reset (async, rst_ni=0) clears all outputs, stall counters and response pipelines; LFSRs load their seeds.
- RAM contents are not reset.
- Reset mid-transaction drops all in-flight responses; no rvalid follows.
- Per-port grant FSM states:
  - IDLE: req=1 with stall_en_i=0 gives gnt_o=1 combinationally in the same cycle.
  - IDLE: req=1 with stall_en_i=1 loads cnt = lfsr % (MAX_GNT_STALL+1). If cnt=0, grant immediately; otherwise go to STALL.
  - STALL: decrement cnt each cycle while req=1. When cnt reaches 0, gnt_o=1 and return to IDLE.
- The LFSR is an 8-bit Galois LFSR, polynomial x^8+x^6+x^5+x^4+1, and advances only on granted cycles.
- Masters must hold req and all attributes stable until gnt; the model does not check this.
- Transfer = req & gnt. Each transfer pushes into a per-port shift pipeline of depth RESP_LATENCY.
- rvalid_o[p] asserts exactly RESP_LATENCY cycles after the transfer; no backpressure. Back-to-back transfers give back-to-back rvalids.
- Reads sample RAM in the transfer cycle, before any same-cycle write, and carry the data down the pipeline.
- Writes update the bytes selected by be_i at the clock edge ending the transfer cycle.
- Same-cycle writes to the same word from several ports: per byte, the lowest-index port wins.
- RAM index = addr[RAM_ADDR_WIDTH-1:2]; higher address bits wrap, except the control region.
- Control region: addr[31:4] == CTRL_BASE[31:4]. Accesses here do not touch RAM and reads return 0.
  - CTRL_BASE+0x0, write 32'd123456789: sets tests_passed_o next cycle.
  - CTRL_BASE+0x0, write 32'd1: sets tests_failed_o next cycle.
  - CTRL_BASE+0x0, any other value: ignored.
  - CTRL_BASE+0x4, write: exit_value_o = wdata and exit_valid_o = 1 for exactly one cycle, both starting the cycle after the transfer.
  - Simultaneous exit writes from several ports: the lowest-index port wins.
- Passed and failed flags are independent and sticky until reset.

Decomposition:
- Package cv32e41p_tb_obi_mem_pkg holds:
  - constants: PASS_MAGIC=123456789, FAIL_MAGIC=1, CTRL_PASS_OFS=0x0, CTRL_EXIT_OFS=0x4, LFSR polynomial mask 8'hB8.
  - typedef grant_state_e {IDLE, STALL}.
- One sub-module, cv32e41p_tb_obi_port, instantiated NUM_PORTS times via generate. It contains the grant FSM, LFSR and response shift pipeline.
- RAM array, write arbitration and control decode stay in the top module.

Test Plan:
- stall_en_i=0, RESP_LATENCY=1: port 0 writes 0xDEADBEEF to 0x100 with be=4'hF, then reads 0x100 → gnt in the request cycle; read rvalid 1 cycle later with rdata=0xDEADBEEF.
- Byte enable: write 0x11223344 with be=4'b0101 over a word of 0 → read returns 0x00220044.
- Same-cycle conflict: port 0 writes 0xAAAAAAAA and port 1 writes 0x55555555 to 0x200 → subsequent read returns 0xAAAAAAAA. A same-cycle read from port 1 of a word port 0 is writing returns the old value.
- stall_en_i=1, MAX_GNT_STALL=3, RESP_LATENCY=3, 20 back-to-back reads on port 1 → every grant stall ≤3 cycles; each rvalid exactly 3 cycles after its grant; stall sequence matches a reference LFSR model seeded 8'hA5^2.
- Control region: write 123456789 to 0x2000_0000, then 7 to 0x2000_0004 → tests_passed_o=1 and tests_failed_o=0; exit_valid_o high for one cycle with exit_value_o=7; RAM word 0x0 unchanged.
- Reset with RESP_LATENCY=3 and 2 reads in flight: assert rst_ni=0 → rvalid_o, gnt_o and all flags go to 0 immediately; no rvalid after release.
